// File: rtl/alu_panel_pkg.sv
// alu_panel_pkg: shared types and constants for the
// ALU panel front-end.
package alu_panel_pkg;

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  localparam int ALU_W  = 4;
  localparam int HIST_EW = 3 + 2 + ALU_W;

  typedef struct packed {
    logic [2:0]       ctrl;
    logic             of;
    logic             car;
    logic [ALU_W-1:0] res;
  } hist_entry_t;

  function automatic int hist_w(input int w);
    return 3 + 2 + w;
  endfunction

endpackage

// File: rtl/alu_hist_buf.sv
// alu_hist_buf: circular history of completed ops
// with saturating count and newest-first read port.
module alu_hist_buf
  import alu_panel_pkg::*;
#(
  parameter int W    = 4,
  parameter int HIST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic [hist_w(W)-1:0]      i_data,
  input  logic [$clog2(HIST)-1:0]   i_idx,
  output logic [hist_w(W)-1:0]      o_data,
  output logic [$clog2(HIST):0]     o_cnt
);

  localparam int AW = $clog2(HIST);
  localparam int EW = hist_w(W);
  localparam logic [AW:0] FULL = (AW+1)'(HIST);

  logic [EW-1:0] r_mem [HIST];
  logic [AW-1:0] r_wp;
  logic [AW:0]   r_cnt;
  logic [AW-1:0] w_addr;
  logic          w_valid;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_wp <= r_wp + AW'(1);
      if (r_cnt != FULL) r_cnt <= r_cnt + 1'b1;
    end
  end

  // newest entry sits just behind the write pointer
  assign w_addr  = r_wp - AW'(1) - i_idx;
  assign w_valid = {1'b0, i_idx} < r_cnt;
  assign o_data  = w_valid ? r_mem[w_addr] : '0;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/alu_panel_ctrl.sv
// alu_panel_ctrl: step-by-step operand/opcode loader
// for the 4-bit ALU with result capture and history.
module alu_panel_ctrl
  import alu_panel_pkg::*;
#(
  parameter int W    = 4,
  parameter int HIST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [W-1:0]            sw,
  input  logic                    btn_next,
  output logic [W-1:0]            alu_a,
  output logic [W-1:0]            alu_b,
  output logic [2:0]              alu_ctrl,
  input  logic [W-1:0]            alu_res,
  input  logic                    alu_car,
  input  logic                    alu_of,
  output logic [2:0]              state,
  output logic                    done,
  output logic [W-1:0]            res_q,
  output logic                    car_q,
  output logic                    of_q,
  input  logic [$clog2(HIST)-1:0] hist_idx,
  output logic [hist_w(W)-1:0]    hist_data,
  output logic [$clog2(HIST):0]   hist_cnt
);

  state_t       r_state;
  state_t       w_nxt;
  logic         w_ld_a;
  logic         w_ld_b;
  logic         w_ld_op;
  logic         w_exec;
  logic         w_push;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [2:0]   r_ctrl;
  logic [W-1:0] r_res;
  logic         r_car;
  logic         r_of;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LOAD_A;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt   = r_state;
    w_ld_a  = 1'b0;
    w_ld_b  = 1'b0;
    w_ld_op = 1'b0;
    w_exec  = 1'b0;
    unique case (r_state)
      S_LOAD_A: if (btn_next) begin
        w_ld_a = 1'b1;
        w_nxt  = S_LOAD_B;
      end
      S_LOAD_B: if (btn_next) begin
        w_ld_b = 1'b1;
        w_nxt  = S_LOAD_OP;
      end
      S_LOAD_OP: if (btn_next) begin
        w_ld_op = 1'b1;
        w_nxt   = S_EXEC;
      end
      S_EXEC: begin
        w_exec = 1'b1;
        w_nxt  = S_SHOW;
      end
      S_SHOW: if (btn_next) w_nxt = S_LOAD_A;
      default: w_nxt = S_LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_ctrl <= '0;
      r_res  <= '0;
      r_car  <= 1'b0;
      r_of   <= 1'b0;
    end else begin
      if (w_ld_a)  r_a    <= sw;
      if (w_ld_b)  r_b    <= sw;
      if (w_ld_op) r_ctrl <= sw[2:0];
      if (w_exec) begin
        r_res <= alu_res;
        r_car <= alu_car;
        r_of  <= alu_of;
      end
    end
  end

  // a reset landing on EXEC must not leave a history entry
  assign w_push = w_exec & ~rst;

  alu_hist_buf #(
    .W    (W),
    .HIST (HIST)
  ) u_hist (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_data ({r_ctrl, alu_of, alu_car, alu_res}),
    .i_idx  (hist_idx),
    .o_data (hist_data),
    .o_cnt  (hist_cnt)
  );

  assign alu_a    = r_a;
  assign alu_b    = r_b;
  assign alu_ctrl = r_ctrl;
  assign state    = r_state;
  assign done     = (r_state == S_SHOW);
  assign res_q    = r_res;
  assign car_q    = r_car;
  assign of_q     = r_of;

endmodule

// File: tb/tb_alu_panel_ctrl.sv
// tb_alu_panel_ctrl: directed and randomized checks of
// the panel controller against an op-level model.
module tb_alu_panel_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       btn_next;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_ctrl;
  logic [3:0] alu_res;
  logic       alu_car;
  logic       alu_of;
  logic [2:0] state;
  logic       done;
  logic [3:0] res_q;
  logic       car_q;
  logic       of_q;
  logic [1:0] hist_idx;
  logic [8:0] hist_data;
  logic [2:0] hist_cnt;

  int checks   = 0;
  int failures = 0;

  logic [8:0] mq[$];

  always #5 clk = ~clk;

  alu_panel_ctrl #(.W(4), .HIST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .btn_next  (btn_next),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .alu_res   (alu_res),
    .alu_car   (alu_car),
    .alu_of    (alu_of),
    .state     (state),
    .done      (done),
    .res_q     (res_q),
    .car_q     (car_q),
    .of_q      (of_q),
    .hist_idx  (hist_idx),
    .hist_data (hist_data),
    .hist_cnt  (hist_cnt)
  );

  // returns {of, car, res}
  function automatic logic [5:0] alu_f(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [2:0] op
  );
    logic [4:0] s;
    logic [3:0] r;
    logic       c;
    logic       o;
    c = 1'b0;
    o = 1'b0;
    s = '0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[3:0];
        c = s[4];
        o = (a[3] == b[3]) && (r[3] != a[3]);
      end
      3'd1: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[3:0];
        c = s[4];
        o = (a[3] != b[3]) && (r[3] != a[3]);
      end
      3'd2: r = ~a;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = {3'b0, $signed(a) < $signed(b)};
      default: r = {3'b0, a == b};
    endcase
    return {o, c, r};
  endfunction

  always_comb begin
    {alu_of, alu_car, alu_res} = alu_f(alu_a, alu_b, alu_ctrl);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [8:0] e);
    mq.push_front(e);
    if (mq.size() > 4) void'(mq.pop_back());
  endtask

  task automatic chk_hist();
    logic [8:0] e;
    chk("hist_cnt", 32'(hist_cnt), 32'(mq.size()));
    for (int i = 0; i < 4; i++) begin
      hist_idx = 2'(i);
      #1;
      e = (i < mq.size()) ? mq[i] : 9'h0;
      chk($sformatf("hist[%0d]", i),
          32'(hist_data), 32'(e));
    end
    hist_idx = 2'd0;
    #1;
  endtask

  task automatic do_step(
    input logic [3:0] v,
    input int         exp_st
  );
    sw = v;
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    chk("step_state", 32'(state), 32'(exp_st));
  endtask

  task automatic idle(input int n, input int exp_st);
    for (int i = 0; i < n; i++) begin
      sw = 4'($urandom);
      tick();
      chk("hold_state", 32'(state), 32'(exp_st));
    end
  endtask

  task automatic run_op(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [2:0] op
  );
    logic [5:0] r;
    logic [3:0] v;
    do_step(a, 1);
    chk("alu_a", 32'(alu_a), 32'(a));
    idle($urandom_range(0, 2), 1);
    do_step(b, 2);
    chk("alu_b", 32'(alu_b), 32'(b));
    idle($urandom_range(0, 2), 2);
    v = {1'($urandom), op};
    do_step(v, 3);
    chk("alu_ctrl", 32'(alu_ctrl), 32'(op));
    chk("done_exec", 32'(done), 32'(0));
    btn_next = 1'($urandom);
    tick();
    btn_next = 1'b0;
    r = alu_f(a, b, op);
    model_push({op, r});
    chk("show_state", 32'(state), 32'(4));
    chk("done", 32'(done), 32'(1));
    chk("res_q", 32'(res_q), 32'(r[3:0]));
    chk("car_q", 32'(car_q), 32'(r[4]));
    chk("of_q", 32'(of_q), 32'(r[5]));
    chk("hist_cnt", 32'(hist_cnt), 32'(mq.size()));
    chk("hist0", 32'(hist_data), 32'(mq[0]));
    idle($urandom_range(0, 2), 4);
    do_step(4'($urandom), 0);
    chk("done_lda", 32'(done), 32'(0));
    chk("a_kept", 32'(alu_a), 32'(a));
    chk("res_kept", 32'(res_q), 32'(r[3:0]));
  endtask

  initial begin
    logic [3:0] hv [5];
    logic [5:0] hr;
    int         seq [5];
    seq = '{1, 2, 3, 4, 0};

    rst = 1'b1;
    sw = 4'hf;
    btn_next = 1'b1;
    hist_idx = 2'd0;
    tick();
    tick();
    rst = 1'b0;
    btn_next = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'(0));
    chk("rst_alu_a", 32'(alu_a), 32'(0));
    chk("rst_alu_b", 32'(alu_b), 32'(0));
    chk("rst_ctrl", 32'(alu_ctrl), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_res", 32'(res_q), 32'(0));
    chk("rst_car", 32'(car_q), 32'(0));
    chk("rst_of", 32'(of_q), 32'(0));
    chk("rst_cnt", 32'(hist_cnt), 32'(0));
    chk("rst_hdata", 32'(hist_data), 32'(0));
    idle(10, 0);

    run_op(4'b0111, 4'b1001, 3'b000);
    chk("add_res", 32'(res_q), 32'(4'b0000));
    chk("add_car", 32'(car_q), 32'(1));
    chk("add_of", 32'(of_q), 32'(0));
    chk("add_hist", 32'(hist_data),
        32'(9'b000_0_1_0000));
    chk("add_cnt", 32'(hist_cnt), 32'(1));

    run_op(4'b0011, 4'b0101, 3'b011);
    chk("and_res", 32'(res_q), 32'(4'b0001));
    chk("and_car", 32'(car_q), 32'(0));
    chk("and_of", 32'(of_q), 32'(0));
    hist_idx = 2'd1;
    #1;
    chk("hist1_prev", 32'(hist_data),
        32'(9'b000_0_1_0000));
    hist_idx = 2'd2;
    #1;
    chk("hist2_empty", 32'(hist_data), 32'(0));
    hist_idx = 2'd0;
    chk_hist();

    for (int k = 0; k < 6; k++)
      run_op(4'($urandom), 4'($urandom), 3'(k));
    chk("wrap_cnt", 32'(hist_cnt), 32'(4));
    hist_idx = 2'd0;
    #1;
    chk("wrap_new", 32'(hist_data[8:6]), 32'(3'b101));
    hist_idx = 2'd3;
    #1;
    chk("wrap_old", 32'(hist_data[8:6]), 32'(3'b010));
    chk_hist();

    for (int k = 0; k < 10; k++)
      run_op(4'($urandom), 4'($urandom),
             3'($urandom));
    chk_hist();

    btn_next = 1'b1;
    for (int k = 0; k < 5; k++) begin
      hv[k] = 4'($urandom);
      sw = hv[k];
      tick();
      chk("held_state", 32'(state), 32'(seq[k]));
      if (k == 3) begin
        hr = alu_f(hv[0], hv[1], hv[2][2:0]);
        model_push({hv[2][2:0], hr});
        chk("held_res", 32'(res_q), 32'(hr[3:0]));
        chk("held_flags", 32'({of_q, car_q}),
            32'(hr[5:4]));
      end
    end
    btn_next = 1'b0;
    chk("held_a", 32'(alu_a), 32'(hv[0]));
    chk("held_b", 32'(alu_b), 32'(hv[1]));
    chk("held_op", 32'(alu_ctrl), 32'(hv[2][2:0]));
    chk_hist();

    do_step(4'd5, 1);
    do_step(4'd6, 2);
    do_step(4'd1, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mq.delete();
    chk("xrst_state", 32'(state), 32'(0));
    chk("xrst_cnt", 32'(hist_cnt), 32'(0));
    chk("xrst_done", 32'(done), 32'(0));
    chk("xrst_res", 32'(res_q), 32'(0));
    chk("xrst_a", 32'(alu_a), 32'(0));
    chk("xrst_hdata", 32'(hist_data), 32'(0));
    tick();
    chk("xrst_hold", 32'(state), 32'(0));
    chk("xrst_cnt2", 32'(hist_cnt), 32'(0));

    run_op(4'($urandom), 4'($urandom), 3'($urandom));
    chk_hist();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=done");
    $fatal(1, "timeout");
  end

endmodule
